// File: rtl/car_link_pkg.sv
// Shared definitions for the car serial link: command byte layout,
// the stop byte, and the UART transmitter state encoding.
package car_link_pkg;

    localparam logic [1:0] CMD_HEADER = 2'b01;
    localparam logic [7:0] STOP_BYTE  = 8'h40;

    localparam int BIT_PLACE   = 5;
    localparam int BIT_DESTROY = 4;
    localparam int BIT_FWD     = 3;
    localparam int BIT_BACK    = 2;
    localparam int BIT_LEFT    = 1;
    localparam int BIT_RIGHT   = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Contradictory pairs cancel so the car never sees both directions at once.
    function automatic logic [7:0] encode_cmd(
        input logic fwd,
        input logic back,
        input logic left,
        input logic right,
        input logic place,
        input logic destroy
    );
        logic [7:0] c;
        c              = 8'h00;
        c[7:6]         = CMD_HEADER;
        c[BIT_PLACE]   = place & ~destroy;
        c[BIT_DESTROY] = destroy & ~place;
        c[BIT_FWD]     = fwd & ~back;
        c[BIT_BACK]    = back & ~fwd;
        c[BIT_LEFT]    = left & ~right;
        c[BIT_RIGHT]   = right & ~left;
        return c;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. A load restarts the period so a frame starts on a clean edge.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign bit_done = (r_cnt == LAST);

endmodule

// File: rtl/move_cmd_uart_tx.sv
// Encodes the six car control inputs into a command byte and sends it as
// an 8N1 frame on change, on keepalive expiry, and once as a stop on disable.
//
// state | meaning
// IDLE  | line high; evaluate send triggers each cycle
// START | start bit (tx=0) for one bit period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (tx=1); frame_sent pulses on exit
module move_cmd_uart_tx
    import car_link_pkg::*;
#(
    parameter int CLK_FREQ         = 100000000,
    parameter int BAUD             = 9600,
    parameter int KEEPALIVE_CYCLES = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic move_forward,
    input  logic move_backward,
    input  logic turn_left,
    input  logic turn_right,
    input  logic place_barrier,
    input  logic destroy_barrier,
    output logic tx,
    output logic busy,
    output logic frame_sent
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);
    localparam logic [KW-1:0] KA_LAST = KW'(KEEPALIVE_CYCLES - 1);

    tx_state_t     r_state;
    logic [7:0]    r_shift;
    logic [7:0]    r_last_sent;
    logic [2:0]    r_bit_idx;
    logic [KW-1:0] r_ka_cnt;
    logic          r_force_send;
    logic          r_enable_d;
    logic          r_tx;
    logic          r_busy;
    logic          r_frame_sent;

    logic [7:0]    w_cmd;
    logic [7:0]    w_byte;
    logic          w_rise;
    logic          w_force;
    logic          w_send_cmd;
    logic          w_send_stop;
    logic          w_load;
    logic          w_bit_done;

    assign w_cmd = encode_cmd(move_forward, move_backward, turn_left,
                              turn_right, place_barrier, destroy_barrier);

    // A re-enable counts as a forced send in the same cycle it is seen.
    assign w_rise      = enable & ~r_enable_d;
    assign w_force     = r_force_send | w_rise;
    assign w_send_cmd  = enable & (w_force | (w_cmd != r_last_sent) | (r_ka_cnt == KA_LAST));
    assign w_send_stop = ~enable & (r_last_sent != STOP_BYTE);
    assign w_load      = (r_state == IDLE) & (w_send_cmd | w_send_stop);
    assign w_byte      = w_send_cmd ? w_cmd : STOP_BYTE;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .bit_done(w_bit_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= 8'h00;
            r_last_sent  <= STOP_BYTE;
            r_bit_idx    <= 3'd0;
            r_ka_cnt     <= '0;
            r_force_send <= 1'b1;
            r_enable_d   <= 1'b0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_sent <= 1'b0;
        end else begin
            r_enable_d   <= enable;
            r_frame_sent <= 1'b0;
            r_force_send <= w_force;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_shift      <= w_byte;
                        r_last_sent  <= w_byte;
                        r_force_send <= 1'b0;
                        r_ka_cnt     <= '0;
                        r_tx         <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= START;
                    end else if (enable && (r_ka_cnt != KA_LAST)) begin
                        r_ka_cnt <= r_ka_cnt + KW'(1);
                    end
                end
                START: begin
                    if (w_bit_done) begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[7:1]};
                        r_bit_idx <= 3'd0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_done) begin
                        r_busy       <= 1'b0;
                        r_frame_sent <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_sent = r_frame_sent;

endmodule

// File: tb/tb_move_cmd_uart_tx.sv
// Scoreboard bench for move_cmd_uart_tx: stimulus queues expected frames
// (byte, start cycle); a line monitor decodes tx and checks each frame.
module tb_move_cmd_uart_tx;

    localparam int CPB = 16;
    localparam int FRAME = 10 * CPB;
    localparam int KA = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;
    logic fwd = 1'b1, back = 1'b0, left = 1'b0, right = 1'b0;
    logic place = 1'b0, destroy = 1'b0;
    logic tx, busy, frame_sent;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] b;
        int         start;
        bit         abort;
    } exp_t;

    exp_t exp_q[$];

    move_cmd_uart_tx #(
        .CLK_FREQ(160),
        .BAUD(10),
        .KEEPALIVE_CYCLES(KA)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .move_forward   (fwd),
        .move_backward  (back),
        .turn_left      (left),
        .turn_right     (right),
        .place_barrier  (place),
        .destroy_barrier(destroy),
        .tx             (tx),
        .busy           (busy),
        .frame_sent     (frame_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b, input int start, input bit abort);
        exp_t e;
        e.b = b;
        e.start = start;
        e.abort = abort;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    bit         rst_q = 1'b1;
    bit         in_frame = 1'b0;
    bit         have_exp;
    bit         shape_err;
    int         f_start;
    logic       slot_val;
    logic [7:0] dec;
    exp_t       cur;

    always @(negedge clk) begin
        int offs;
        int slot;
        if (rst_q) begin
            if (in_frame) begin
                check("abort_expected", 32'(cur.abort), 32'd1);
                in_frame = 1'b0;
            end
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_frame_sent", 32'(frame_sent), 32'd0);
        end else if (!in_frame) begin
            check("idle_frame_sent", 32'(frame_sent), 32'd0);
            if (tx === 1'b0) begin
                in_frame  = 1'b1;
                f_start   = cyc;
                shape_err = 1'b0;
                dec       = 8'h00;
                slot_val  = 1'b0;
                have_exp  = (exp_q.size() != 0);
                check("expected_frame_queued", 32'(have_exp), 32'd1);
                if (have_exp) begin
                    cur = exp_q.pop_front();
                    check("start_cycle", 32'(cyc), 32'(cur.start));
                end else begin
                    cur.b = 8'h00;
                    cur.start = -1;
                    cur.abort = 1'b0;
                end
                check("start_busy", 32'(busy), 32'd1);
            end
        end else begin
            offs = cyc - f_start;
            slot = offs / CPB;
            if (offs < FRAME) begin
                if (offs % CPB == 0) slot_val = tx;
                else if (tx !== slot_val) shape_err = 1'b1;
                if (slot == 0 && tx !== 1'b0) shape_err = 1'b1;
                if (slot == 9 && tx !== 1'b1) shape_err = 1'b1;
                if (slot >= 1 && slot <= 8 && offs % CPB == CPB / 2) dec[slot-1] = tx;
                if (busy !== 1'b1 || frame_sent !== 1'b0) shape_err = 1'b1;
            end else begin
                check("frame_shape", 32'(shape_err), 32'd0);
                check("frame_byte", 32'(dec), 32'(cur.b));
                check("frame_not_aborted", 32'(cur.abort), 32'd0);
                check("end_frame_sent", 32'(frame_sent), 32'd1);
                check("end_busy", 32'(busy), 32'd0);
                check("end_tx", 32'(tx), 32'd1);
                in_frame = 1'b0;
            end
        end
        rst_q = reset;
    end

    // ---------------- stimulus ----------------
    initial begin
        int r, s3, t, c, c2, u, v, w;

        // 1: reset release with fwd; 2: two keepalive repeats
        wait_until(3);
        reset = 1'b0;
        r = cyc;
        push(8'h48, r + 1, 1'b0);
        push(8'h48, r + 1 + FRAME + KA, 1'b0);
        s3 = r + 1 + 2 * (FRAME + KA);
        push(8'h48, s3, 1'b0);

        // 3: fwd -> left during data bit 3
        wait_until(s3 + CPB + 3 * CPB + 6);
        fwd = 1'b0;
        left = 1'b1;
        t = s3 + FRAME + 1;
        push(8'h42, t, 1'b0);

        // 4: place&destroy cancel, then fwd&back cancel with left
        wait_until(t + FRAME + 10);
        left = 1'b0;
        place = 1'b1;
        destroy = 1'b1;
        c = cyc;
        push(8'h40, c + 1, 1'b0);
        wait_until(c + 1 + FRAME + 10);
        place = 1'b0;
        destroy = 1'b0;
        fwd = 1'b1;
        back = 1'b1;
        left = 1'b1;
        c2 = cyc;
        u = c2 + 1;
        push(8'h42, u, 1'b0);

        // 5: disable mid-frame -> one stop frame, then silence, then re-enable
        wait_until(u + 50);
        enable = 1'b0;
        push(8'h40, u + FRAME + 1, 1'b0);
        wait_until(u + FRAME + 1 + FRAME + 300);
        enable = 1'b1;
        v = cyc;
        push(8'h42, v + 1, 1'b1);

        // 6: reset during data bit 5, then full resend
        wait_until(v + 1 + CPB + 5 * CPB + 4);
        reset = 1'b1;
        wait_until(cyc + 2);
        reset = 1'b0;
        w = cyc;
        push(8'h42, w + 1, 1'b0);

        while ((exp_q.size() != 0 || in_frame) && cyc < w + 2 * FRAME) begin
            @(posedge clk);
            #1;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        wait_until(cyc + 20);
        check("final_idle_tx", 32'(tx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
